// File: rtl/erythcrypt_pkg.sv
// Shared types and constants for the erythcrypt command feeder.
// Legal opcodes are 0 .. OP_MAX; anything above is rejected when ERYTHCRYPT_OPCHECK_EN is defined.
package erythcrypt_pkg;

    localparam int OP_W  = 4;
    localparam int DAT_W = 8;
    localparam int CMD_W = OP_W + 2 * DAT_W;

    localparam logic [OP_W-1:0] OP_MAX = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_CAPTURE,
        ST_WAIT_ACK
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [DAT_W-1:0] a;
        logic [DAT_W-1:0] b;
    } cmd_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/erythcrypt_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), pointers wrap naturally, occupancy count
// one bit wider than the pointers so that full and empty are distinguishable.
module erythcrypt_cmd_fifo
    import erythcrypt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CMD_W-1:0] wdata,
    input  logic             pop,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // simultaneous push and pop leaves the count unchanged
        cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/erythcrypt_cmd_feeder.sv
// Queues commands and presents each one to the crypt core for HOLD_CYCLES, then captures the result.
// Optional opcode screening is enabled by defining ERYTHCRYPT_OPCHECK_EN.
module erythcrypt_cmd_feeder
    import erythcrypt_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [DAT_W-1:0] cmd_a,
    input  logic [DAT_W-1:0] cmd_b,
    output logic [DAT_W-1:0] I1,
    output logic [DAT_W-1:0] I2,
    output logic [OP_W-1:0]  Control,
    input  logic [DAT_W-1:0] OUTPUT,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DAT_W-1:0] res_data,
    output logic [OP_W-1:0]  res_op,
    output logic             busy,
    output logic             err_op
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [DAT_W-1:0] i1_q, i1_d, i2_q, i2_d, res_data_q, res_data_d;
    logic [OP_W-1:0]  ctl_q, ctl_d, res_op_q, res_op_d;
    logic             res_valid_q, res_valid_d;

    logic             hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;
    cmd_t             head;

    assign hs   = cmd_valid && cmd_ready;
    assign head = cmd_t'(fifo_rdata);

`ifdef ERYTHCRYPT_OPCHECK_EN
    logic err_q, err_d;

    // illegal opcodes still complete the handshake but never reach the queue
    assign fifo_push = hs && op_legal(cmd_op);
    assign err_d     = err_q || (hs && !op_legal(cmd_op));
    assign err_op    = err_q;

    always_ff @(posedge CLK) begin
        if (Reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign fifo_push = hs;
    assign err_op    = 1'b0;
`endif

    erythcrypt_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .push  (fifo_push),
        .wdata (CMD_W'({cmd_op, cmd_a, cmd_b})),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        ctl_d       = ctl_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    i1_d     = head.a;
                    i2_d     = head.b;
                    ctl_d    = head.op;
                    hold_d   = HOLD_LD;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) state_d = ST_CAPTURE;
                else              hold_d  = hold_q - 1'b1;
            end
            ST_CAPTURE: begin
                res_data_d  = OUTPUT;
                res_op_d    = ctl_q;
                res_valid_d = 1'b1;
                state_d     = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            ctl_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            ctl_q       <= ctl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign I1        = i1_q;
    assign I2        = i2_q;
    assign Control   = ctl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_erythcrypt_cmd_feeder.sv
// Directed/randomized bench for erythcrypt_cmd_feeder; a fake crypt core computes OUTPUT from
// I1/I2/Control and a queue of accepted commands predicts every result.
module tb_erythcrypt_cmd_feeder;

    localparam int DEPTH = 4;
    localparam int HOLD  = 50;
`ifdef ERYTHCRYPT_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } tcmd_t;

    logic       CLK = 1'b0;
    logic       Reset, cmd_valid, res_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       cmd_ready, res_valid, busy, err_op;
    logic [7:0] I1, I2, OUTPUT, res_data;
    logic [3:0] Control, res_op;

    int    checks = 0;
    int    failures = 0;
    tcmd_t q[$];
    bit    err_exp = 1'b0;

    function automatic logic [7:0] core_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return (a ^ {b[3:0], b[7:4]}) + {op, op};
    endfunction

    assign OUTPUT = core_f(Control, I1, I2);

    erythcrypt_cmd_feeder #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .I1(I1), .I2(I2),
        .Control(Control), .OUTPUT(OUTPUT), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .busy(busy), .err_op(err_op)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input tcmd_t c);
        if (OPCHK && c.op > 4'd11) err_exp = 1'b1;
        else                       q.push_back(c);
    endtask

    task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        tcmd_t c;
        bit    done;
        c = '{op: op, a: a, b: b};
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            if (cmd_ready) begin
                model_accept(c);
                done = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) chk("offer_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic wait_res(input string tag);
        tcmd_t e;
        for (int n = 0; n < 400 && res_valid !== 1'b1; n++) tick();
        chk({tag, "_arrive"}, {31'd0, res_valid}, 32'd1);
        e = '0;
        if (q.size() != 0) e = q.pop_front();
        chk({tag, "_data"}, {24'd0, res_data}, {24'd0, core_f(e.op, e.a, e.b)});
        chk({tag, "_op"}, {28'd0, res_op}, {28'd0, e.op});
    endtask

    initial begin
        tcmd_t c;
        int    acc;
        bit    seen;
        logic [7:0] hold_data;

        Reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_control", {28'd0, Control}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_i1_i2", {16'd0, I1, I2}, 32'd0);
        chk("rst_res", {20'd0, res_op, res_data}, 32'd0);
        chk("rst_err", {31'd0, err_op}, 32'd0);

        // latency: push at cycle N, Control at N+2, res_valid at N+53
        res_ready = 1'b1;
        offer(4'd1, 8'd30, 8'd70);
        chk("lat_ctl_n1", {28'd0, Control}, 32'd0);
        tick();
        chk("lat_ctl_n2", {28'd0, Control}, 32'd1);
        chk("lat_i1_i2", {16'd0, I1, I2}, {16'd0, 8'd30, 8'd70});
        for (int k = 0; k < HOLD; k++) begin
            tick();
            chk("lat_hold_ctl", {28'd0, Control}, 32'd1);
            chk("lat_no_res", {31'd0, res_valid}, 32'd0);
        end
        tick();
        chk("lat_res_valid", {31'd0, res_valid}, 32'd1);
        chk("lat_res_data", {24'd0, res_data}, {24'd0, core_f(4'd1, 8'd30, 8'd70)});
        chk("lat_res_op", {28'd0, res_op}, 32'd1);
        void'(q.pop_front());
        tick();
        chk("lat_res_drop", {31'd0, res_valid}, 32'd0);
        chk("lat_idle_busy", {31'd0, busy}, 32'd0);

        // back-pressure: DEPTH queued + one in flight, then in-order drain
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            c = '{op: 4'($urandom_range(11, 0)), a: 8'($urandom), b: 8'($urandom)};
            cmd_op = c.op; cmd_a = c.a; cmd_b = c.b; cmd_valid = 1'b1;
            if (cmd_ready) begin
                acc++;
                model_accept(c);
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", acc, DEPTH + 1);
        chk("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        res_ready = 1'b1;
        for (int k = 0; k < acc; k++) begin
            wait_res("bp");
            tick();
        end

        // result held across a long stall; next command waits for the ack
        res_ready = 1'b0;
        offer(4'd3, 8'($urandom), 8'($urandom));
        offer(4'd7, 8'($urandom), 8'($urandom));
        wait_res("stall_a");
        hold_data = res_data;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_data", {24'd0, res_data}, {24'd0, hold_data});
            chk("stall_op", {28'd0, res_op}, 32'd3);
            chk("stall_ctl", {28'd0, Control}, 32'd3);
        end
        res_ready = 1'b1;
        tick();
        chk("stall_ack_drop", {31'd0, res_valid}, 32'd0);
        wait_res("stall_b");
        tick();

        // reset mid-HOLD with three commands queued
        for (int i = 0; i < 4; i++) offer(4'($urandom_range(11, 0)), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 10; k++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        q.delete();
        chk("mrst_ctl", {28'd0, Control}, 32'd0);
        chk("mrst_i1_i2", {16'd0, I1, I2}, 32'd0);
        chk("mrst_res", {19'd0, res_valid, res_op, res_data}, 32'd0);
        chk("mrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        chk("mrst_no_result", {31'd0, seen}, 32'd0);

        // illegal opcode then a legal one
        offer(4'b1100, 8'($urandom), 8'($urandom));
        offer(4'b0010, 8'($urandom), 8'($urandom));
        tick();
        chk("op_err", {31'd0, err_op}, {31'd0, err_exp});
        while (q.size() != 0) begin
            wait_res("op");
            tick();
        end
        seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        chk("op_no_extra", {31'd0, seen}, 32'd0);
        chk("op_err_sticky", {31'd0, err_op}, {31'd0, err_exp});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
